// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   the parity selector codes already used by the UART, and a small
//   index-wrap helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_EVEN = 2'd1;
    localparam logic [1:0] PARITY_ODD  = 2'd2;

    // (idx + 1) mod n for idx already in [0, n-1]; avoids a real modulo.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter
//   Purely combinational rotating-priority arbiter. The search starts at
//   ptr and the first asserted request wins.
// Ports:
//   req    in  NUM_REQ : request vector
//   ptr    in  ID_W    : highest-priority index this cycle
//   gnt    out NUM_REQ : one-hot grant (all zero when no request)
//   gnt_id out ID_W    : binary index of the grant (0 when none)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    int              sum;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = ID_W'(sum);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters with
//   round-robin arbitration and packet locking. A winner keeps the grant
//   until it sends a byte marked last or stays idle for LOCK_TIMEOUT cycles.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/data/last, req_ready : requester byte handshake (ready one-hot)
//   uart_data_in, uart_write_en, uart_write_busy : UART write interface
//   grant_active    : a packet lock is held
//   grant_id        : locked or last-served requester
//   timeout_pulse   : one-cycle pulse when a lock is dropped by timeout
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int ID_W         = $clog2(NUM_REQ)   // derived, do not override
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         uart_data_in,
    output logic                         uart_write_en,
    input  logic                         uart_write_busy,
    output logic                         grant_active,
    output logic [ID_W-1:0]              grant_id,
    output logic                         timeout_pulse
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [CNT_W-1:0]   idle_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_id;
    logic [NUM_REQ-1:0] sel;
    logic [ID_W-1:0]    win_id;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    // While locked only the lock holder is eligible; otherwise the
    // rotating arbiter picks. The busy gate also covers a reset that
    // landed mid-frame, when the UART is still shifting.
    always_comb begin
        sel       = grant_active ? (NUM_REQ'(1) << grant_id) : arb_gnt;
        win_id    = grant_active ? grant_id : arb_id;
        req_ready = '0;
        if (!rst && state == ST_IDLE && !uart_write_busy)
            req_ready = sel & req_valid;
        accept = |req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            uart_write_en <= 1'b0;
            uart_data_in  <= '0;
            grant_active  <= 1'b0;
            grant_id      <= '0;
            timeout_pulse <= 1'b0;
            ptr           <= '0;
            idle_cnt      <= '0;
        end else begin
            uart_write_en <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        uart_data_in  <= req_data[win_id*DATA_BITS +: DATA_BITS];
                        grant_id      <= win_id;
                        grant_active  <= !req_last[win_id];
                        idle_cnt      <= '0;
                        uart_write_en <= 1'b1;
                        state         <= ST_ISSUE;
                        if (req_last[win_id])
                            ptr <= ID_W'(wrap_inc(int'(win_id), NUM_REQ));
                    end else if (grant_active) begin
                        // A waiting-but-valid holder (UART still busy) is not idle.
                        if (req_valid[grant_id]) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == CNT_LAST) begin
                            grant_active  <= 1'b0;
                            timeout_pulse <= 1'b1;
                            idle_cnt      <= '0;
                            ptr           <= ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE:     state <= ST_WAIT_BUSY;
                ST_WAIT_BUSY: if (uart_write_busy)  state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (!uart_write_busy) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

endmodule
